aq_jpeg_rgb2ycbcr_blk: RTL and testbench
========================================

// Module: aq_jpeg_rgb2ycbcr_blk
// PURPOSE
//  Encoder-side colour converter. Accepts RGB pixels in any order within a block and converts them to level-shifted signed YCbCr.
//  Writes each result into a ping-pong pair of 256-entry block buffers and hands each full block to the downstream DCT stage.
//  It is the inverse of the decode-path YCbCr->RGB stage and uses the same block geometry:
//  3 comp = 16x16 MCU; 1 comp = 32x8.
// PARAMETERS
//  FRAC_BITS  14  coefficient fraction bits; each coefficient = round(c*2^FRAC_BITS)
// PORTS
//  clk          in   1   clock; all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  InComp       in   3   component count (3 or 1); sampled on first pixel of each block
//  InEnable     in   1   pixel valid
//  InReady      out  1   pixel accepted when InEnable & InReady
//  InPixelX     in   16  pixel column
//  InPixelY     in   16  pixel row
//  InR/InG/InB  in   8   unsigned colour
//  BufWrite     out  1   buffer write strobe
//  BufBank      out  1   bank being written
//  BufAddress   out  8   word address within bank
//  BufY/BufCb/BufCr out 9  signed two's complement, Y level-shifted by -128
//  OutEnable    out  1   a full block is available
//  OutBank      out  1   bank holding that block
//  OutBlockX    out  12  block coordinate
//  OutBlockY    out  12  block coordinate
//  OutComp      out  3   component count of the block
//  OutRelease   in   1   one-cycle pulse: downstream finished with OutBank
// BEHAVIOUR
//  Reset: all registered outputs = 0, both banks free, fill bank = 0, pixel count = 0; InReady = 1 in the first cycle after reset.
//  Accept: InReady = !owned[fill_bank]. Each accept increments the 8-bit count.
//  On the accept that wraps the count 255->0: mark fill_bank pending and toggle fill_bank.
//  First accept of a block (count==0) latches InComp, BlockX and BlockY into that bank's descriptor.
//  Address and block mapping:
//   comp==3: addr={Y[3:0],X[3:0]}; BlockX=X[15:4]; BlockY=Y[15:4].
//   otherwise: addr={X[4],Y[2:0],X[3:0]}; BlockX={1'b0,X[15:5]}; BlockY=Y[14:3].
//  Pipeline: 3 stages, BufWrite asserted exactly 3 cycles after accept; bank and address travel with the data.
//   S1: products Y=4899R+9617G+1868B; Cb=-2765R-5427G+8192B; Cr=8192R-6860G-1332B (FRAC_BITS=14).
//   S2: add 2^(FRAC_BITS-1); arithmetic shift right by FRAC_BITS (floor).
//   S3: Y-=128; register into the 9-bit outputs. Ranges: Y -128..127; Cb/Cr -128..128. No clipping needed.
//  Block handoff: a bank becomes "owned" when its 256th write leaves S3 (pending->owned).
//   OutEnable=1 while the oldest owned bank is unreleased; OutBank/OutBlockX/OutBlockY/OutComp show that bank's descriptor.
//   Banks are presented strictly in fill order.
//   OutRelease frees OutBank next cycle; OutEnable re-asserts the following cycle if the other bank is owned.
//   OutRelease while OutEnable=0 is ignored.
//  Ownership and InReady: owned covers both the pending state and the owned state, so InReady stays low from bank-full until release.
//  Same-cycle events: release of bank b and accept into bank !b both take effect. A bank is owned as soon as its last pixel is
//   accepted and InReady gates on owned, so a release of bank b and an accept into bank b cannot happen in the same cycle;
//   the fill bank is never the bank being released.
//  Mid-block InComp changes are ignored until the next block.
//  Reset mid-operation: pipeline contents discarded (no BufWrite after reset), descriptors cleared, partial block lost.
// CONFIGURATION
//  AQ_RGB2YCBCR_ERRCHK_EN defined:
//   - adds output ErrSeq (1 bit), reset 0, sticky until rst.
//   - set when an accepted pixel with count!=0 maps to a BlockX/BlockY different from the latched descriptor.
//   - the pixel is still written.
//  Macro undefined: port and logic absent; behaviour otherwise identical.
// TESTING
//  T1 R=G=B=0 -> BufY=-128 (0x180), Cb=0, Cr=0; R=G=B=255 -> Y=127 (0x07F), Cb=0, Cr=0; each 3 cycles after accept.
//  T2 R=255,G=0,B=0 -> Y=-52, Cb=-43, Cr=128; R=0,G=0,B=255 -> Y=-99, Cb=128, Cr=-21.
//  T3 comp=3, X=0x0023, Y=0x0015 -> addr 0x53, block (2,1).
//     comp=1, X=0x0035, Y=0x000A -> addr 0xA5, block (1,1).
//  T4 512 pixels, no release -> OutEnable for bank0 then bank1 kept queued; InReady=0 after accept 512.
//     Pulse OutRelease -> OutBank=1 two cycles later, InReady=1, fill resumes in bank0.
//  T5 rst asserted after 100 pixels (pipeline full) -> no further BufWrite.
//     Next block starts at bank0 with OutEnable=0 until 256 new pixels.
//  T6 (ERRCHK_EN) pixel 5 of block (0,0) with X=0x0010 -> ErrSeq=1 and stays 1 until rst.

Source files
------------

// File: rtl/aq_jpeg_rgb2ycbcr_blk.sv
// RGB -> level-shifted YCbCr converter that fills ping-pong 256-word block banks for the DCT stage.
// Optional block-sequence error flag ErrSeq is built when AQ_RGB2YCBCR_ERRCHK_EN is defined.
module aq_jpeg_rgb2ycbcr_blk #(
  parameter int FRAC_BITS = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  InComp,
  input  logic        InEnable,
  output logic        InReady,
  input  logic [15:0] InPixelX,
  input  logic [15:0] InPixelY,
  input  logic [7:0]  InR,
  input  logic [7:0]  InG,
  input  logic [7:0]  InB,
  output logic        BufWrite,
  output logic        BufBank,
  output logic [7:0]  BufAddress,
  output logic [8:0]  BufY,
  output logic [8:0]  BufCb,
  output logic [8:0]  BufCr,
  output logic        OutEnable,
  output logic        OutBank,
  output logic [11:0] OutBlockX,
  output logic [11:0] OutBlockY,
  output logic [2:0]  OutComp,
  input  logic        OutRelease
`ifdef AQ_RGB2YCBCR_ERRCHK_EN
  ,
  output logic        ErrSeq
`endif
);

  // Coefficients given in millionths, rounded to FRAC_BITS fraction bits.
  function automatic int coef(input longint c_e6);
    return int'(((c_e6 <<< FRAC_BITS) + 64'sd500000) / 64'sd1000000);
  endfunction

  localparam int K_YR  = coef(64'sd299000);
  localparam int K_YG  = coef(64'sd587000);
  localparam int K_YB  = coef(64'sd114000);
  localparam int K_CBR = coef(64'sd168736);
  localparam int K_CBG = coef(64'sd331264);
  localparam int K_H   = coef(64'sd500000);
  localparam int K_CRG = coef(64'sd418688);
  localparam int K_CRB = coef(64'sd81312);
  localparam int RND   = 1 << (FRAC_BITS - 1);

  typedef enum logic [1:0] {BK_FREE, BK_PEND, BK_OWN} bank_st_t;

  bank_st_t    r_st [2];
  bank_st_t    w_st_nxt [2];
  logic        r_fill;
  logic [7:0]  r_cnt;
  logic [2:0]  r_dcomp [2];
  logic [11:0] r_dbx [2];
  logic [11:0] r_dby [2];
  logic        r_oe;
  logic        r_ob;

  logic [2:0]       r_vld_pipe;
  logic [2:0]       r_bank_pipe;
  logic [2:0]       r_last_pipe;
  logic [2:0][7:0]  r_addr_pipe;

  logic signed [31:0] r_p_y, r_p_cb, r_p_cr;
  logic signed [9:0]  r_s_y, r_s_cb, r_s_cr;

  logic               w_acc, w_rel, w_c3;
  logic [2:0]         w_comp;
  logic [7:0]         w_addr;
  logic [11:0]        w_bx, w_by;
  logic signed [31:0] w_r, w_g, w_b;
  logic signed [31:0] w_s_y, w_s_cb, w_s_cr;
  logic signed [9:0]  w_y3;

  assign InReady = (r_st[r_fill] == BK_FREE);
  assign w_acc   = InEnable & InReady;
  assign w_rel   = OutRelease & r_oe;

  // Geometry follows the latched block component count, not a mid-block InComp change.
  assign w_comp = (r_cnt == 8'd0) ? InComp : r_dcomp[r_fill];
  assign w_c3   = (w_comp == 3'd3);
  assign w_addr = w_c3 ? {InPixelY[3:0], InPixelX[3:0]}
                       : {InPixelX[4], InPixelY[2:0], InPixelX[3:0]};
  assign w_bx   = w_c3 ? InPixelX[15:4] : {1'b0, InPixelX[15:5]};
  assign w_by   = w_c3 ? InPixelY[15:4] : InPixelY[14:3];

  assign w_r = $signed({24'd0, InR});
  assign w_g = $signed({24'd0, InG});
  assign w_b = $signed({24'd0, InB});

  assign w_s_y  = (r_p_y  + RND) >>> FRAC_BITS;
  assign w_s_cb = (r_p_cb + RND) >>> FRAC_BITS;
  assign w_s_cr = (r_p_cr + RND) >>> FRAC_BITS;
  assign w_y3   = r_s_y - 10'sd128;

  assign BufWrite   = r_vld_pipe[2];
  assign BufBank    = r_bank_pipe[2];
  assign BufAddress = r_addr_pipe[2];
  assign OutEnable  = r_oe;
  assign OutBank    = r_ob;
  assign OutBlockX  = r_dbx[r_ob];
  assign OutBlockY  = r_dby[r_ob];
  assign OutComp    = r_dcomp[r_ob];

  // Release never targets the fill bank, so the three updates touch distinct banks.
  always_comb begin
    w_st_nxt = r_st;
    if (w_rel) w_st_nxt[r_ob] = BK_FREE;
    if (r_vld_pipe[2] && r_last_pipe[2]) w_st_nxt[r_bank_pipe[2]] = BK_OWN;
    if (w_acc && r_cnt == 8'hFF) w_st_nxt[r_fill] = BK_PEND;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st[0]    <= BK_FREE;
      r_st[1]    <= BK_FREE;
      r_fill     <= 1'b0;
      r_cnt      <= 8'd0;
      r_dcomp[0] <= '0;
      r_dcomp[1] <= '0;
      r_dbx[0]   <= '0;
      r_dbx[1]   <= '0;
      r_dby[0]   <= '0;
      r_dby[1]   <= '0;
      r_oe       <= 1'b0;
      r_ob       <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (w_acc) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == 8'hFF) r_fill <= ~r_fill;
        if (r_cnt == 8'd0) begin
          r_dcomp[r_fill] <= InComp;
          r_dbx[r_fill]   <= w_bx;
          r_dby[r_fill]   <= w_by;
        end
      end
      // One dead cycle after a release before the next owned bank is offered.
      if (w_rel) begin
        r_oe <= 1'b0;
        r_ob <= ~r_ob;
      end else begin
        r_oe <= (r_st[r_ob] == BK_OWN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_bank_pipe <= '0;
      r_last_pipe <= '0;
      r_addr_pipe <= '0;
      r_p_y  <= '0;
      r_p_cb <= '0;
      r_p_cr <= '0;
      r_s_y  <= '0;
      r_s_cb <= '0;
      r_s_cr <= '0;
      BufY   <= '0;
      BufCb  <= '0;
      BufCr  <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[1:0], w_acc};
      r_bank_pipe <= {r_bank_pipe[1:0], r_fill};
      r_last_pipe <= {r_last_pipe[1:0], (r_cnt == 8'hFF)};
      r_addr_pipe <= {r_addr_pipe[1:0], w_addr};
      r_p_y  <= K_YR * w_r + K_YG * w_g + K_YB * w_b;
      r_p_cb <= K_H * w_b - K_CBR * w_r - K_CBG * w_g;
      r_p_cr <= K_H * w_r - K_CRG * w_g - K_CRB * w_b;
      r_s_y  <= w_s_y[9:0];
      r_s_cb <= w_s_cb[9:0];
      r_s_cr <= w_s_cr[9:0];
      BufY   <= w_y3[8:0];
      BufCb  <= r_s_cb[8:0];
      BufCr  <= r_s_cr[8:0];
    end
  end

`ifdef AQ_RGB2YCBCR_ERRCHK_EN
  logic r_err;
  assign ErrSeq = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (w_acc && r_cnt != 8'd0 &&
             (w_bx != r_dbx[r_fill] || w_by != r_dby[r_fill])) r_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_aq_jpeg_rgb2ycbcr_blk.sv
// Randomized bench for aq_jpeg_rgb2ycbcr_blk with a pixel-level reference model and scoreboard.
module tb_aq_jpeg_rgb2ycbcr_blk;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  InComp = 3'd3;
  logic        InEnable = 1'b0;
  logic        InReady;
  logic [15:0] InPixelX = '0, InPixelY = '0;
  logic [7:0]  InR = '0, InG = '0, InB = '0;
  logic        BufWrite, BufBank;
  logic [7:0]  BufAddress;
  logic [8:0]  BufY, BufCb, BufCr;
  logic        OutEnable, OutBank;
  logic [11:0] OutBlockX, OutBlockY;
  logic [2:0]  OutComp;
  logic        OutRelease = 1'b0;
`ifdef AQ_RGB2YCBCR_ERRCHK_EN
  logic        ErrSeq;
`endif

  always #5 clk = ~clk;

  aq_jpeg_rgb2ycbcr_blk dut (
    .clk(clk), .rst(rst), .InComp(InComp), .InEnable(InEnable), .InReady(InReady),
    .InPixelX(InPixelX), .InPixelY(InPixelY), .InR(InR), .InG(InG), .InB(InB),
    .BufWrite(BufWrite), .BufBank(BufBank), .BufAddress(BufAddress),
    .BufY(BufY), .BufCb(BufCb), .BufCr(BufCr),
    .OutEnable(OutEnable), .OutBank(OutBank), .OutBlockX(OutBlockX), .OutBlockY(OutBlockY),
    .OutComp(OutComp), .OutRelease(OutRelease)
`ifdef AQ_RGB2YCBCR_ERRCHK_EN
    , .ErrSeq(ErrSeq)
`endif
  );

  typedef struct { int due; logic [35:0] dat; } exp_t;
  exp_t q[$];

  int  n_chk = 0, n_err = 0, ncyc = 0;
  bit  mon_on = 0;
  int  m_cnt, m_fill, m_ob, m_x, m_y, m_c;
  bit  m_owned[2];
  int  m_comp[2], m_bx[2], m_by[2];
  int  perm[256];

  int          dr[4] = '{0, 255, 255, 0};
  int          dg[4] = '{0, 255, 0, 0};
  int          db[4] = '{0, 255, 0, 255};
  logic [8:0]  dy[4]  = '{9'h180, 9'h07F, 9'h1CC, 9'h19D};
  logic [8:0]  dcb[4] = '{9'h000, 9'h000, 9'h1D5, 9'h080};
  logic [8:0]  dcr[4] = '{9'h000, 9'h000, 9'h080, 9'h1EB};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int blk_x(int comp, int x);
    return (comp == 3) ? x / 16 : x / 32;
  endfunction

  function automatic int blk_y(int comp, int y);
    return (comp == 3) ? y / 16 : (y / 8) % 4096;
  endfunction

  // Expected buffer word from colour-space arithmetic and block geometry.
  function automatic logic [35:0] mdl(int bank, int x, int y, int comp, int r, int g, int b);
    int a, yy, cb, cr;
    logic [8:0] y9, cb9, cr9;
    logic [7:0] a8;
    a  = (comp == 3) ? (y % 16) * 16 + x % 16
                     : ((x / 16) % 2) * 128 + (y % 8) * 16 + x % 16;
    yy = ((4899 * r + 9617 * g + 1868 * b + 8192) >>> 14) - 128;
    cb = (-2765 * r - 5427 * g + 8192 * b + 8192) >>> 14;
    cr = (8192 * r - 6860 * g - 1332 * b + 8192) >>> 14;
    a8 = a[7:0]; y9 = yy[8:0]; cb9 = cb[8:0]; cr9 = cr[8:0];
    return {bank[0], a8, y9, cb9, cr9};
  endfunction

  task automatic m_reset();
    q.delete();
    m_cnt = 0; m_fill = 0; m_ob = 0;
    for (int i = 0; i < 2; i++) begin
      m_owned[i] = 0; m_comp[i] = 0; m_bx[i] = 0; m_by[i] = 0;
    end
  endtask

  // Scoreboard: every accept predicts one write exactly three cycles later.
  always @(negedge clk) begin
    ncyc++;
    if (mon_on) begin
      if (q.size() > 0 && q[0].due == ncyc) begin
        chk("wr", BufWrite, 1);
        chk("wdat", {BufBank, BufAddress, BufY, BufCb, BufCr}, q[0].dat);
        void'(q.pop_front());
      end else begin
        chk("wr_idle", BufWrite, 0);
      end
      if (rst) m_reset();
      else begin
        chk("rdy", InReady, !m_owned[m_fill]);
        if (InEnable && InReady) begin
          m_x = InPixelX; m_y = InPixelY;
          m_c = (m_cnt == 0) ? int'(InComp) : m_comp[m_fill];
          if (m_cnt == 0) begin
            m_comp[m_fill] = m_c;
            m_bx[m_fill] = blk_x(m_c, m_x);
            m_by[m_fill] = blk_y(m_c, m_y);
          end
          q.push_back('{due: ncyc + 3,
                        dat: mdl(m_fill, m_x, m_y, m_c, int'(InR), int'(InG), int'(InB))});
          m_cnt = (m_cnt + 1) % 256;
          if (m_cnt == 0) begin
            m_owned[m_fill] = 1;
            m_fill ^= 1;
          end
        end
        if (OutRelease && OutEnable) begin
          m_owned[m_ob] = 0;
          m_ob ^= 1;
        end
      end
    end
  end

  task automatic drive_px(input int x, input int y, input int r, input int g, input int b,
                          input int comp);
    int t;
    InPixelX = 16'(x); InPixelY = 16'(y);
    InR = 8'(r); InG = 8'(g); InB = 8'(b); InComp = 3'(comp);
    InEnable = 1'b1;
    t = 0;
    @(negedge clk);
    while (!InReady && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (!InReady) chk("rdy_to", InReady, 1);
    @(posedge clk); #1;
    InEnable = 1'b0;
  endtask

  task automatic wait_wr();
    int t;
    t = 0;
    @(negedge clk);
    while (!BufWrite && t < 8) begin
      t++;
      @(negedge clk);
    end
    chk("wr_to", BufWrite, 1);
    chk("lat", t, 2);
  endtask

  task automatic wait_oe();
    int t;
    t = 0;
    @(negedge clk);
    while (!OutEnable && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("oe_to", OutEnable, 1);
    @(posedge clk); #1;
  endtask

  task automatic release_blk();
    OutRelease = 1'b1;
    @(posedge clk); #1;
    OutRelease = 1'b0;
  endtask

  task automatic idx2xy(input int comp, input int bx, input int by, input int idx,
                        output int x, output int y);
    if (comp == 3) begin
      x = bx * 16 + idx % 16;
      y = by * 16 + idx / 16;
    end else begin
      x = bx * 32 + ((idx / 128) % 2) * 16 + idx % 16;
      y = by * 8 + (idx / 16) % 8;
    end
  endtask

  // Sends npx pixels of a block in random order, starting at word 'first'.
  task automatic run_block(input int comp, input int bx, input int by, input int first,
                           input bit dir, input bit rndc, input int npx);
    int x, y, c, t, j;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 256; i++)
      if (perm[i] == first) begin
        perm[i] = perm[0];
        perm[0] = first;
      end
    for (int i = 0; i < npx; i++) begin
      idx2xy(comp, bx, by, perm[i], x, y);
      c = (i > 0 && rndc) ? (($urandom_range(0, 1) == 1) ? 3 : 1) : comp;
      if (dir && i < 4) begin
        drive_px(x, y, dr[i], dg[i], db[i], c);
        wait_wr();
        if (i == 0) chk("addr0", BufAddress, first);
        chk("dirY", BufY, dy[i]);
        chk("dirCb", BufCb, dcb[i]);
        chk("dirCr", BufCr, dcr[i]);
        @(posedge clk); #1;
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk); #1;
        end
        drive_px(x, y, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), c);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int x, y;
    m_reset();
    mon_on = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", InReady, 1);
    chk("rst_oe", OutEnable, 0);
    chk("rst_wr", BufWrite, 0);
    chk("rst_ob", OutBank, 0);
    chk("rst_addr", BufAddress, 0);
    chk("rst_bufy", BufY, 0);
    chk("rst_obx", OutBlockX, 0);
    chk("rst_ocomp", OutComp, 0);
`ifdef AQ_RGB2YCBCR_ERRCHK_EN
    chk("rst_err", ErrSeq, 0);
`endif
    @(posedge clk); #1;

    // comp=3 block (2,1) led by X=0x23,Y=0x15 -> word 0x53
    run_block(3, 2, 1, 'h53, 1, 0, 256);
    wait_oe();
    chk("A_bank", OutBank, 0);
    chk("A_bx", OutBlockX, 2);
    chk("A_by", OutBlockY, 1);
    chk("A_comp", OutComp, 3);
    release_blk();

    // comp=1 block (1,1) led by X=0x35,Y=0x0A -> word 0xA5; InComp wobbles mid-block
    run_block(1, 1, 1, 'hA5, 1, 1, 256);
    wait_oe();
    chk("B_bank", OutBank, 1);
    chk("B_bx", OutBlockX, 1);
    chk("B_by", OutBlockY, 1);
    chk("B_comp", OutComp, 1);
    release_blk();

    // two blocks with no release: both banks queued, input stalls
    run_block(3, 5, 7, 0, 0, 1, 256);
    run_block(1, 3, 2, 0, 0, 0, 256);
    repeat (6) @(negedge clk);
    chk("full_rdy", InReady, 0);
    @(posedge clk); #1;
    wait_oe();
    chk("C_bank", OutBank, 0);
    chk("C_bx", OutBlockX, 5);
    chk("C_by", OutBlockY, 7);
    InPixelX = 16'h00A0; InPixelY = 16'h0070; InComp = 3'd3; InEnable = 1'b1;
    repeat (8) @(posedge clk);
    #1 InEnable = 1'b0;
    // second release cycle lands while OutEnable is low and must be ignored
    OutRelease = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    OutRelease = 1'b0;
    @(negedge clk);
    chk("D_oe", OutEnable, 1);
    chk("D_bank", OutBank, 1);
    chk("D_rdy", InReady, 1);
    chk("D_bx", OutBlockX, 3);
    chk("D_by", OutBlockY, 2);
    chk("D_comp", OutComp, 1);
    @(posedge clk); #1;

    // refill bank0, then reset with the pipeline busy
    run_block(3, 0, 3, 0, 1, 0, 100);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_nowr", BufWrite, 0);
    end
    chk("rst2_oe", OutEnable, 0);
    chk("rst2_rdy", InReady, 1);
    chk("rst2_ob", OutBank, 0);
    @(posedge clk); #1;
    run_block(3, 1, 0, 0, 0, 0, 255);
    repeat (8) @(negedge clk);
    chk("E_oe_early", OutEnable, 0);
    @(posedge clk); #1;
    idx2xy(3, 1, 0, perm[255], x, y);
    drive_px(x, y, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 3);
    wait_oe();
    chk("E_bank", OutBank, 0);
    chk("E_bx", OutBlockX, 1);
    chk("E_by", OutBlockY, 0);
    release_blk();

`ifdef AQ_RGB2YCBCR_ERRCHK_EN
    chk("err_clean", ErrSeq, 0);
    for (int i = 0; i < 4; i++) drive_px(i, 0, 10, 20, 30, 3);
    chk("err_pre", ErrSeq, 0);
    drive_px(16'h0010, 0, 40, 50, 60, 3);
    chk("err_set", ErrSeq, 1);
    drive_px(4, 0, 1, 2, 3, 3);
    drive_px(5, 0, 1, 2, 3, 3);
    repeat (4) @(posedge clk);
    #1 chk("err_stick", ErrSeq, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_rst", ErrSeq, 0);
`endif

    repeat (10) @(negedge clk);
    chk("q_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
